midi_rx: RTL
============

MIDI_RX -- requirements
Module: midi_rx

Interface
REQ-001 The parameter CLKS_PER_BIT SHALL default to 384 and give clk cycles per serial bit (384 = 12 MHz / 31250 baud); legal values are >= 4.
REQ-002 The parameter FIFO_DEPTH SHALL default to 4 and give the number of received-byte entries; legal values are powers of 2, >= 2.
REQ-003 The parameter ACT_TICKS SHALL default to 3 and give the number of ledclk_en pulses that activity stays high after a byte.
REQ-004 The port clk SHALL be an input, 1 bit wide: the single system clock.
REQ-005 The port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-006 The port inport SHALL be an input, 1 bit wide: MIDI serial line, idle high, asynchronous to clk.
REQ-007 The port rxdata SHALL be an output, 8 bits wide: FIFO head byte, valid while rx_empty=0.
REQ-008 The port rx_empty SHALL be an output, 1 bit wide: FIFO holds no bytes.
REQ-009 The port rx_rden SHALL be an input, 1 bit wide: pop the FIFO head on this cycle.
REQ-010 The port rx_overflow SHALL be an output, 1 bit wide: one-cycle pulse when a received byte is dropped because the FIFO is full.
REQ-011 The port framing_err SHALL be an output, 1 bit wide: one-cycle pulse when a stop bit is sampled low.
REQ-012 The port activity_in SHALL be an output, 1 bit wide: LED drive, stretched on every accepted byte.
REQ-013 The port ledclk_en SHALL be an input, 1 bit wide: slow tick strobe, one clk cycle wide.

Function
REQ-014 inport SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-015 The state machine SHALL have the states IDLE, START, DATA and STOP.
REQ-016 IDLE -> START SHALL occur on a synchronized 1->0 transition; the bit counter SHALL clear.
REQ-017 In START, at CLKS_PER_BIT/2 cycles (integer division), a low line SHALL go to DATA and a high line SHALL go to IDLE as a glitch, with no flags raised.
REQ-018 DATA SHALL sample 8 bits, one every CLKS_PER_BIT cycles, LSB first, then go to STOP.
REQ-019 STOP SHALL sample once after a further CLKS_PER_BIT cycles and return to IDLE on the next cycle, so back-to-back frames are accepted.
REQ-020 A high stop sample SHALL push the byte into the FIFO.
REQ-021 A low stop sample SHALL discard the byte and pulse framing_err for 1 cycle.
REQ-022 Latency: rx_empty SHALL deassert on the cycle after the stop sample when the FIFO was empty.
REQ-023 The FIFO SHALL be first-word-fall-through: rxdata SHALL show the head with no read latency.
REQ-024 rx_rden while rx_empty=1 SHALL be ignored, with no pointer change.
REQ-025 A push while full with no pop on that cycle SHALL drop the new byte, keep the stored contents and pulse rx_overflow.
REQ-026 A push and a pop on the same cycle SHALL both take effect, including when full (no overflow) and when empty with a pop request (push only).
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be held in a counter of width log2(FIFO_DEPTH)+1.
REQ-028 activity_in SHALL rise on the cycle after any accepted push and fall after ACT_TICKS further ledclk_en pulses.
REQ-029 A new push while activity_in is high SHALL reload the tick count.

Reset
REQ-030 Asserting rst SHALL immediately force state=IDLE, FIFO empty (rx_empty=1), rxdata=0x00, rx_overflow=0, framing_err=0, activity_in=0, and both synchronizer flops to 1.
REQ-031 rst asserted mid-frame SHALL abandon the frame.
REQ-032 After rst releases, a line held low SHALL NOT start a frame until a 1->0 transition is seen.

Configuration
REQ-033 With MIDI_RX_ACTIVE_SENSE_FILTER_EN defined, a correctly framed byte 0xFE SHALL NOT be pushed, SHALL NOT trigger activity_in and SHALL NOT cause overflow.
REQ-034 Without MIDI_RX_ACTIVE_SENSE_FILTER_EN, 0xFE SHALL be treated as any other byte.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4, ACT_TICKS=3)
REQ-035 Sending the frame 0x90 -> rx_empty falls 1 cycle after the stop sample, rxdata=0x90; one rx_rden -> rx_empty=1.
REQ-036 A 3-cycle low glitch on idle inport -> state back to IDLE, rx_empty stays 1, no framing_err.
REQ-037 Sending 0x3C with the stop bit forced low -> framing_err pulses once, rx_empty stays 1.
REQ-038 Sending 0x01..0x05 back-to-back with no reads -> rx_overflow pulses once (on 0x05); reads return 0x01..0x04, then rx_empty=1.
REQ-039 FIFO full with rx_rden on the push cycle of 0x77 -> no overflow; the last read returns 0x77.
REQ-040 Sending 0xFE then 0x80 -> with the macro, only 0x80 is read; without the macro, 0xFE then 0x80 are read; activity_in falls after 3 ledclk_en pulses following the last push.

Source files
------------

// File: rtl/midi_rx.sv
// MIDI serial receiver: 2-flop synchronizer, 8N1 frame decoder, FWFT byte FIFO, activity LED stretcher.
// Optional build macro MIDI_RX_ACTIVE_SENSE_FILTER_EN drops correctly framed 0xFE (active sense) bytes.
module midi_rx #(
    parameter int unsigned CLKS_PER_BIT = 384,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned ACT_TICKS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inport,
    output logic [7:0] rxdata,
    output logic       rx_empty,
    input  logic       rx_rden,
    output logic       rx_overflow,
    output logic       framing_err,
    output logic       activity_in,
    input  logic       ledclk_en
);
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned NW   = AW + 1;
    localparam int unsigned TW   = (ACT_TICKS < 1) ? 1 : $clog2(ACT_TICKS + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          sync1, sync2, fill1, fill2, armed;
    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shift, shift_d;
    logic          start_c, stop_good_c, stop_bad_c, keep_c;
    logic          push_c, pop_c, full_c, wr_c;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic [TW-1:0] act_cnt;

    // Synchronizer; fill flags mark when sync2 holds a real line sample rather than its reset value.
    // armed requires the line to be seen high in IDLE before a low can start a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync1 <= inport;
            sync2 <= sync1;
            fill1 <= 1'b1;
            fill2 <= fill1;
            if (start_c)
                armed <= 1'b0;
            else if (state == IDLE && fill2 && sync2)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            shift   <= shift_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt + CW'(1);
        bit_d       = bit_idx;
        shift_d     = shift;
        start_c     = 1'b0;
        stop_good_c = 1'b0;
        stop_bad_c  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (armed && !sync2) begin
                    state_d = START;
                    start_c = 1'b1;
                end
            end
            START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    state_d = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2, shift[7:1]};
                    bit_d   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    stop_good_c = sync2;
                    stop_bad_c  = !sync2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MIDI_RX_ACTIVE_SENSE_FILTER_EN
    assign keep_c = (shift != 8'hFE);
`else
    assign keep_c = 1'b1;
`endif

    assign push_c = stop_good_c && keep_c;
    assign full_c = (count == NW'(FIFO_DEPTH));
    assign pop_c  = rx_rden && (count != '0);
    assign wr_c   = push_c && (!full_c || pop_c);

    // Storage needs no reset: rxdata is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (wr_c)
            mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_overflow <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (wr_c)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_c, pop_c})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            rx_overflow <= push_c && full_c && !pop_c;
            framing_err <= stop_bad_c;
        end
    end

    assign rx_empty = (count == '0);
    assign rxdata   = rx_empty ? 8'h00 : mem[rd_ptr];

    // LED stretcher: each accepted byte reloads the tick budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_cnt     <= '0;
            activity_in <= 1'b0;
        end else if (wr_c) begin
            act_cnt     <= TW'(ACT_TICKS);
            activity_in <= (ACT_TICKS != 0);
        end else if (ledclk_en && act_cnt != '0) begin
            act_cnt     <= act_cnt - TW'(1);
            activity_in <= (act_cnt != TW'(1));
        end
    end
endmodule
